// File: rtl/tt_um_uart_spi.sv
// Tiny Tapeout top: 8N1 UART transceiver and 16-bit SPI slave.
// Received data is read back on uio_out through a byte-select mux.
module tt_um_uart_spi #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int          BIT_CYC   = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
  localparam logic [15:0] HALF_LAST = 16'(BIT_CYC / 2 - 1);

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in};

  // Two-stage synchronisers for ui_in[7:2]; prev_q gives edge detection.
  // Bit 0 (uart_rx) resets high to match the idle line.
  logic [5:0] meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 6'b000001;
      sync_q <= 6'b000001;
      prev_q <= 6'b000001;
    end else begin
      meta_q <= ui_in[7:2];
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  logic rx_bit, rx_fall, tx_rise, sclk_rise, sclk_fall, sdi_bit;
  logic cs_now, cs_prev, cs_rise, cs_fall;

  assign rx_bit    = sync_q[0];
  assign rx_fall   = prev_q[0] & ~sync_q[0];
  assign tx_rise   = sync_q[1] & ~prev_q[1];
  assign sclk_rise = sync_q[3] & ~prev_q[3];
  assign sclk_fall = prev_q[3] & ~sync_q[3];
  assign sdi_bit   = sync_q[4];
  assign cs_now    = sync_q[5] & sync_q[2];
  assign cs_prev   = prev_q[5] & prev_q[2];
  assign cs_rise   = cs_now & ~cs_prev;
  assign cs_fall   = cs_prev & ~cs_now;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_idx_q;
  logic [7:0]  rx_sh_q, rx_data_q;
  logic        rx_valid_q, frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= 16'd0;
      rx_idx_q    <= 3'd0;
      rx_sh_q     <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= 16'd0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= 16'd0;
            rx_idx_q   <= 3'd0;
            rx_state_q <= rx_bit ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= 16'd0;
            rx_sh_q  <= {rx_bit, rx_sh_q[7:1]};
            rx_idx_q <= rx_idx_q + 3'd1;
            if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_state_q <= RX_IDLE;
            if (rx_bit) begin
              rx_data_q   <= rx_sh_q;
              rx_valid_q  <= 1'b1;
              frame_err_q <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  tx_state_t   tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_idx_q;
  logic [8:0]  tx_sh_q;
  logic        tx_q;

  // The byte is latched into tx_sh_q at the trigger, so later RX updates
  // cannot disturb a frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_idx_q   <= 4'd0;
      tx_sh_q    <= 9'h1FF;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (tx_rise) begin
            tx_sh_q    <= {1'b1, rx_data_q};
            tx_q       <= 1'b0;
            tx_cnt_q   <= 16'd0;
            tx_idx_q   <= 4'd0;
            tx_state_q <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= 16'd0;
            if (tx_idx_q == 4'd9) begin
              tx_state_q <= TX_IDLE;
              tx_q       <= 1'b1;
            end else begin
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
              tx_idx_q <= tx_idx_q + 4'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  logic tx_busy;
  assign tx_busy = (tx_state_q == TX_SEND);

  logic [15:0] spi_in_q, spi_out_q, spi_rx_q, spi_tx_q;
  logic [4:0]  spi_cnt_q;
  logic        spi_done_q, spi_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_in_q   <= 16'd0;
      spi_out_q  <= 16'd0;
      spi_rx_q   <= 16'd0;
      spi_tx_q   <= 16'd0;
      spi_cnt_q  <= 5'd0;
      spi_done_q <= 1'b0;
      spi_busy_q <= 1'b0;
    end else if (cs_rise) begin
      spi_done_q <= 1'b0;
      spi_cnt_q  <= 5'd0;
      spi_out_q  <= spi_tx_q;
      spi_busy_q <= 1'b1;
    end else if (cs_fall) begin
      if (spi_cnt_q == 5'd16) begin
        spi_rx_q   <= spi_in_q;
        spi_tx_q   <= spi_in_q;
        spi_done_q <= 1'b1;
      end
      spi_busy_q <= 1'b0;
    end else if (cs_now) begin
      if (sclk_rise) begin
        spi_in_q <= {spi_in_q[14:0], sdi_bit};
        if (spi_cnt_q != 5'd16) spi_cnt_q <= spi_cnt_q + 5'd1;
      end
      if (sclk_fall) spi_out_q <= {spi_out_q[14:0], 1'b0};
    end
  end

  logic spi_sdo;
  assign spi_sdo = cs_prev & spi_out_q[15];

  assign uo_out = {1'b0, spi_busy_q, spi_sdo, spi_done_q, frame_err_q,
                   tx_busy, rx_valid_q, tx_q};
  assign uio_oe = 8'hFF;

  always_comb begin
    uio_out = 8'h00;
    case (ui_in[1:0])
      2'b00: uio_out = rx_data_q;
      2'b01: uio_out = spi_rx_q[7:0];
      2'b10: uio_out = spi_rx_q[15:8];
      2'b11: uio_out = {4'b0, spi_done_q, frame_err_q, tx_busy, spi_busy_q};
      default: uio_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tt_um_uart_spi.sv
// Self-checking bench for tt_um_uart_spi, run with a short baud divider
// (16 clocks per bit) so whole frames fit in a small cycle budget.
module tb_tt_um_uart_spi;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int BITC     = CLK_FREQ / BAUD;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] sel;
  logic rx, txs, en, sclk, sdi, cs;
  logic [7:0] ui_in;
  assign ui_in = {cs, sdi, sclk, en, txs, rx, sel};
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uio_in = 8'h00;
  logic ena = 1'b1;

  tt_um_uart_spi #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard queues and reference model
  logic [7:0]  exp_rx_q[$];
  int          exp_rx_t[$];
  logic [7:0]  exp_tx_q[$];
  logic [15:0] exp_spi_q[$];
  logic [7:0]  m_rx_byte = 8'h00;
  logic [15:0] m_spi_word = 16'h0000;
  logic        m_done = 1'b0;

  // driver tasks
  task automatic uart_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(negedge clk);
    if (stop) begin
      exp_rx_q.push_back(b);
      exp_rx_t.push_back(cyc);
      m_rx_byte = b;
    end
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (BITC) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BITC) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [15:0] w, input int nbits);
    logic [15:0] sh, exp_out;
    logic        active, b;
    active  = en;
    exp_out = m_spi_word;
    sh      = 16'h0000;
    @(negedge clk);
    sclk = 1'b0;
    cs   = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (nbits < 16)             b = w[15 - i];
      else if (i < nbits - 16)    b = 1'($urandom_range(0, 1));
      else                        b = w[15 - (i - (nbits - 16))];
      sdi = b;
      sh  = {sh[14:0], b};
      repeat (8) @(negedge clk);
      if (i < 16) check("spi_sdo", uo_out[5], active ? exp_out[15 - i] : 1'b0);
      if (i == 8) check("spi_busy_in_frame", uo_out[6], active);
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    if (active) begin
      if (nbits >= 16) begin
        exp_spi_q.push_back(sh);
        m_spi_word = sh;
        m_done = 1'b1;
      end else begin
        m_done = 1'b0;
      end
    end
    cs = 1'b0;
    repeat (12) @(negedge clk);
    check("spi_busy_after", uo_out[6], 1'b0);
    check("spi_done_level", uo_out[4], m_done);
  endtask

  // monitor: UART RX completions
  initial begin
    logic [7:0] e;
    int t, lat;
    forever begin
      @(negedge clk);
      if (rst_n && uo_out[1]) begin
        if (exp_rx_q.size() == 0) begin
          check("uart_rx_unexpected", exp_rx_q.size(), 1);
        end else begin
          e = exp_rx_q.pop_front();
          t = exp_rx_t.pop_front();
          lat = cyc - t;
          check("uart_rx_data", uio_out, e);
          check("uart_rx_ferr_clear", uo_out[3], 1'b0);
          check("uart_rx_latency_ok", (lat >= 146 && lat <= 164), 1'b1);
        end
      end
    end
  end

  // monitor: UART TX frames, sampled at bit centres
  initial begin
    logic [9:0] got;
    logic       bsy_ok;
    forever begin
      @(negedge clk);
      if (rst_n && !uo_out[0]) begin
        bsy_ok = 1'b1;
        repeat (BITC / 2) @(negedge clk);
        for (int b = 0; b < 10; b++) begin
          got[b] = uo_out[0];
          bsy_ok = bsy_ok & uo_out[2];
          if (b < 9) repeat (BITC) @(negedge clk);
        end
        if (exp_tx_q.size() == 0) begin
          check("uart_tx_unexpected", exp_tx_q.size(), 1);
        end else begin
          check("uart_tx_data", got[8:1], exp_tx_q.pop_front());
          check("uart_tx_start", got[0], 1'b0);
          check("uart_tx_stop", got[9], 1'b1);
          check("uart_tx_busy", bsy_ok, 1'b1);
        end
      end
    end
  end

  // monitor: SPI completions, reads both word bytes through the mux
  logic done_prev = 1'b0;
  initial begin
    logic [7:0] lo, hi;
    forever begin
      @(negedge clk);
      if (rst_n && uo_out[4] && !done_prev) begin
        sel = 2'b01;
        @(negedge clk);
        lo = uio_out;
        sel = 2'b10;
        @(negedge clk);
        hi = uio_out;
        sel = 2'b00;
        if (exp_spi_q.size() == 0) check("spi_unexpected_done", exp_spi_q.size(), 1);
        else check("spi_rx_word", {hi, lo}, exp_spi_q.pop_front());
      end
      done_prev = rst_n ? uo_out[4] : 1'b0;
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    logic [1:0] s;
    check({tag, "_uo_out"}, uo_out, 8'h01);
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      sel = s;
      #1;
      check({tag, "_uio_out"}, uio_out, 8'h00);
    end
    sel = 2'b00;
  endtask

  // main sequence
  initial begin
    logic [7:0] prev_byte;
    sel = 2'b00; rx = 1'b1; txs = 1'b0; en = 1'b0;
    sclk = 1'b0; sdi = 1'b0; cs = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    check("uio_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    uart_send(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    uart_send(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check("uio_sel00", uio_out, m_rx_byte);

    exp_tx_q.push_back(m_rx_byte);
    txs = 1'b1;
    repeat (4) @(negedge clk);
    txs = 1'b0;
    repeat (40) @(negedge clk);
    check("tx_busy_mid", uo_out[2], 1'b1);
    txs = 1'b1;
    repeat (4) @(negedge clk);
    txs = 1'b0;
    repeat (220) @(negedge clk);
    check("tx_busy_end", uo_out[2], 1'b0);
    check("tx_queue_drained", exp_tx_q.size(), 0);

    prev_byte = m_rx_byte;
    uart_send(8'hFF, 1'b0);
    repeat (20) @(negedge clk);
    check("frame_err_set", uo_out[3], 1'b1);
    check("frame_err_data_kept", uio_out, prev_byte);
    sel = 2'b11;
    #1;
    check("status_byte", uio_out, {4'b0, m_done, 1'b1, 1'b0, 1'b0});
    sel = 2'b00;
    for (int i = 0; i < 3; i++) begin
      uart_send(8'($urandom_range(0, 255)), 1'b1);
      repeat (10) @(negedge clk);
    end
    check("frame_err_cleared", uo_out[3], 1'b0);

    en = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      spi_frame(16'(k), 16);
      repeat (6) @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      spi_frame(16'($urandom_range(0, 65535)), 16 + 2 * k);
      repeat (6) @(negedge clk);
    end

    spi_frame(16'($urandom_range(0, 65535)), 8);
    sel = 2'b01; #1; check("short_lo_kept", uio_out, m_spi_word[7:0]);
    sel = 2'b10; #1; check("short_hi_kept", uio_out, m_spi_word[15:8]);
    sel = 2'b00;
    spi_frame(16'($urandom_range(0, 65535)), 16);
    repeat (6) @(negedge clk);

    en = 1'b0;
    repeat (4) @(negedge clk);
    spi_frame(16'($urandom_range(0, 65535)), 16);
    sel = 2'b01; #1; check("disabled_lo_kept", uio_out, m_spi_word[7:0]);
    sel = 2'b10; #1; check("disabled_hi_kept", uio_out, m_spi_word[15:8]);
    sel = 2'b00;
    en = 1'b1;
    repeat (4) @(negedge clk);
    spi_frame(16'($urandom_range(0, 65535)), 16);
    repeat (6) @(negedge clk);

    fork
      uart_send(8'($urandom_range(0, 255)), 1'b1);
      spi_frame(16'($urandom_range(0, 65535)), 16);
    join
    repeat (10) @(negedge clk);

    rx = 1'b0;
    cs = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sdi = 1'($urandom_range(0, 1));
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    rx = 1'b1; cs = 1'b0; sclk = 1'b0; sdi = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    m_rx_byte = 8'h00; m_spi_word = 16'h0000; m_done = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_uio", uio_out, 8'h00);
    uart_send(8'($urandom_range(0, 255)), 1'b1);
    repeat (10) @(negedge clk);
    spi_frame(16'($urandom_range(0, 65535)), 16);
    repeat (6) @(negedge clk);
    spi_frame(16'($urandom_range(0, 65535)), 16);

    repeat (50) @(negedge clk);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("spi_queue_drained", exp_spi_q.size(), 0);
    check("tx_queue_final", exp_tx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
